// File: rtl/mips_pkg.sv
// Shared MIPS-style definitions: opcodes, fetch FSM encoding and instruction width.
// Pure declarations; no logic, latency or flow control.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b100011;
    localparam logic [5:0] OP_BNE   = 6'b100111;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JAL   = 6'b111001;

    typedef enum logic {
        FETCH  = 1'b0,
        DECODE = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC select: jump target over taken branch over sequential pc+4.
// Purely combinational, zero latency, no flow control.
module pc_next_logic
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               jump,
    input  logic               branch_taken,
    output logic [ADDR_W-1:0]  next_pc
);

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic              w_unused_op;

    assign w_pc_plus4   = pc + ADDR_W'(4);
    // Jump stays inside the 256 MB region of the delay-slot address.
    assign w_jump_tgt   = {w_pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
    assign w_branch_tgt = w_pc_plus4 + {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign w_unused_op  = ^instr[31:26];

    always_comb begin
        next_pc = w_pc_plus4;
        if (jump)
            next_pc = w_jump_tgt;
        else if (branch_taken)
            next_pc = w_branch_tgt;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: holds pc, fetches over imem req/ready, holds instr for decode until !stall.
// New pc on imem_addr one cycle after consume; memory wait states and decode stalls both hold state.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    input  logic               stall,
    input  logic               jump,
    input  logic               branch_taken,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_instr_valid;
    logic [ADDR_W-1:0]  w_next_pc;

    pc_next_logic #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc           (r_pc),
        .instr        (r_instr),
        .jump         (jump),
        .branch_taken (branch_taken),
        .next_pc      (w_next_pc)
    );

    // Reset has priority, so a late imem_ready in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_state       <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    assign imem_req    = (r_state == FETCH) && !reset;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + ADDR_W'(4);
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a pc-arithmetic reference model.
module tb_fetch_unit;
    import mips_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .stall        (stall),
        .jump         (jump),
        .branch_taken (branch_taken),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        int          waits;
        int          stalls;
        bit          j;
        bit          b;
    } tx_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    // 0 idle, 1 fetching, 2 holding for decode, 3 reset edge pending, 4 reset applied
    int          phase       = 3;
    logic [31:0] model_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_empty_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: scoreboard empty while DUT presents a transaction", name);
    endtask

    // Architectural next-pc rule, stated with integer arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input bit j, input bit b);
        logic [31:0] seq;
        logic [31:0] idx;
        int          off;
        seq = cur + 32'd4;
        if (j) begin
            idx = ins & 32'h03FF_FFFF;
            return (seq & 32'hF000_0000) | (idx * 32'd4);
        end
        if (b) begin
            off = int'($signed(ins[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    function automatic tx_t mk(input logic [31:0] ins, input int w, input int s,
                               input bit j, input bit b);
        tx_t t;
        t.instr  = ins;
        t.waits  = w;
        t.stalls = s;
        t.j      = j;
        t.b      = b;
        return t;
    endfunction

    // Monitor: samples on the falling edge, compares against the scoreboard front.
    always @(negedge clk) begin
        case (phase)
            1: begin
                chk("fetch_req", 32'(imem_req), 32'd1);
                chk("fetch_valid_low", 32'(instr_valid), 32'd0);
                if (sb.size() == 0) sb_empty_fail("fetch_addr");
                else chk("fetch_addr", imem_addr, sb[0].pc);
            end
            2: begin
                chk("decode_req_low", 32'(imem_req), 32'd0);
                chk("decode_valid", 32'(instr_valid), 32'd1);
                if (sb.size() == 0) begin
                    sb_empty_fail("decode_instr");
                end else begin
                    chk("decode_instr", instr, sb[0].instr);
                    chk("decode_opcode", 32'(opcode), 32'(sb[0].instr >> 26));
                    chk("decode_pc", pc, sb[0].pc);
                    chk("decode_pc_plus4", pc_plus4, sb[0].pc + 32'd4);
                    if (!stall) void'(sb.pop_front());
                end
            end
            3: chk("reset_req_low", 32'(imem_req), 32'd0);
            4: begin
                chk("reset_req_low", 32'(imem_req), 32'd0);
                chk("reset_pc", pc, RESET_PC);
                chk("reset_instr", instr, 32'h0);
                chk("reset_valid", 32'(instr_valid), 32'd0);
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_ctrl();
        jump         = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input bit late_ready);
        phase      = 3;
        reset      = 1'b1;
        imem_ready = late_ready;
        imem_rdata = $urandom;
        noise_ctrl();
        tick();
        phase      = 4;
        imem_ready = 1'b0;
        tick();
        reset      = 1'b0;
        sb.delete();
        model_pc   = RESET_PC;
    endtask

    task automatic run_tx(input tx_t t);
        exp_t e;
        e.pc    = model_pc;
        e.instr = t.instr;
        sb.push_back(e);
        model_pc = ref_next(model_pc, t.instr, t.j, t.b);
        phase = 1;
        for (int i = 0; i < t.waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            stall      = 1'($urandom_range(0, 1));
            noise_ctrl();
            tick();
        end
        imem_ready = 1'b1;
        imem_rdata = t.instr;
        stall      = 1'($urandom_range(0, 1));
        noise_ctrl();
        tick();
        phase = 2;
        for (int i = 0; i < t.stalls; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            stall      = 1'b1;
            noise_ctrl();
            tick();
        end
        imem_ready   = 1'($urandom_range(0, 1));
        imem_rdata   = $urandom;
        stall        = 1'b0;
        jump         = t.j;
        branch_taken = t.b;
        tick();
    endtask

    tx_t dir[$];

    initial begin
        tx_t  t;
        exp_t e;
        logic [5:0] op;
        reset        = 1'b1;
        imem_ready   = 1'b0;
        imem_rdata   = '0;
        stall        = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        model_pc     = RESET_PC;
        tick();
        do_reset(1'b0);

        dir.push_back(mk(32'h0, 0, 0, 0, 0));                          // 0x0
        dir.push_back(mk(32'h0, 0, 0, 0, 0));                          // 0x4
        dir.push_back(mk(32'h0, 0, 0, 0, 0));                          // 0x8
        dir.push_back(mk(32'h0, 0, 0, 0, 0));                          // 0xC
        dir.push_back(mk(32'h8C01_2345, 3, 0, 0, 0));                  // 0x10 wait states
        dir.push_back(mk(32'h1234_5678, 0, 5, 0, 0));                  // 0x14 long stall
        dir.push_back(mk(32'h0, 0, 0, 0, 0));                          // 0x18
        dir.push_back(mk(32'h0, 0, 0, 0, 0));                          // 0x1C
        dir.push_back(mk({OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 0, 1)); // 0x20 -> 0x1C
        dir.push_back(mk(32'h0, 0, 0, 0, 0));                          // 0x1C
        dir.push_back(mk({OP_BEQ, 5'd1, 5'd2, 16'h0003}, 0, 0, 0, 1)); // 0x20 -> 0x30
        dir.push_back(mk({OP_J, 26'h0000008}, 0, 0, 1, 0));            // 0x30 -> 0x20
        dir.push_back(mk({OP_BEQ, 5'd1, 5'd2, 16'h0003}, 1, 0, 0, 0)); // 0x20 -> 0x24
        dir.push_back(mk({OP_J, 26'h0000010}, 0, 0, 1, 0));            // 0x24 -> 0x40
        dir.push_back(mk({OP_J, 26'h0000100}, 0, 2, 1, 1));           // 0x40 -> 0x400
        dir.push_back(mk({OP_BNE, 5'd3, 5'd4, 16'hFEFE}, 0, 0, 0, 1)); // 0x400 -> 0xFFFFFFFC
        dir.push_back(mk(32'h0, 0, 0, 0, 0));                          // wrap -> 0x0
        dir.push_back(mk({OP_JAL, 26'h0000020}, 0, 1, 1, 0));          // 0x0 -> 0x80
        foreach (dir[i]) run_tx(dir[i]);

        // Abandon a fetch at 0x80 with a late ready in the reset cycle.
        e.pc    = model_pc;
        e.instr = 32'h0;
        sb.push_back(e);
        phase      = 1;
        imem_ready = 1'b0;
        tick();
        do_reset(1'b1);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_RTYPE;
                1: op = OP_BEQ;
                2: op = OP_BNE;
                3: op = OP_J;
                4: op = OP_JAL;
                default: op = 6'($urandom);
            endcase
            t.instr  = {op, 26'($urandom)};
            t.waits  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            t.stalls = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            t.j      = ($urandom_range(0, 3) == 0);
            t.b      = ($urandom_range(0, 2) == 0);
            run_tx(t);
        end

        phase = 0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
